// File: rtl/audio_prbs_tx.sv
// rtl/audio_prbs_tx.sv - PRBS/ramp/constant 12-bit test sample transmitter with delayed reference copy
// Optional corruption of every ERR_PERIOD-th sample: define AUDIO_PRBS_ERR_INJECT_EN.
module audio_prbs_tx #(
  parameter int          WIDTH      = 12,
  parameter logic [14:0] SEED       = 15'h0001,
  parameter int          REF_DELAY  = 4,
  parameter int          ERR_PERIOD = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      div,
  input  logic [15:0]      burst_len,
  input  logic             ready,
  output logic [WIDTH-1:0] sample,
  output logic             valid,
  output logic [WIDTH-1:0] ref_sample,
  output logic             ref_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [14:0]      SeedEff  = (SEED == 15'd0) ? 15'd1 : SEED;
  localparam logic [WIDTH-1:0] ConstVal = WIDTH'(12'hA5A);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [15:0]      div_q, div_d;
  logic [15:0]      blen_q, blen_d;
  logic [15:0]      divcnt_q, divcnt_d;
  logic [14:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  logic [15:0]      count_q, count_d;
  logic [WIDTH-1:0] ref_data_q [REF_DELAY];
  logic [WIDTH-1:0] ref_data_d [REF_DELAY];
  logic [REF_DELAY-1:0] ref_vld_q, ref_vld_d;

  logic             start_ok;
  logic             hs;
  logic [15:0]      count_inc;
  logic             last_hs;
  logic [WIDTH-1:0] gen_val;
  logic [WIDTH-1:0] err_mask;

  // start is honoured only when no burst is in flight
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign hs        = (state_q == S_PRESENT) && ready;
  assign count_inc = count_q + 16'd1;
  assign last_hs   = (blen_q != 16'd0) && (count_inc == blen_q);

  always_comb begin
    gen_val = lfsr_q[WIDTH-1:0];
    case (mode_q)
      2'b01:   gen_val = ramp_q;
      2'b10:   gen_val = ConstVal;
      default: gen_val = lfsr_q[WIDTH-1:0];
    endcase
  end

`ifdef AUDIO_PRBS_ERR_INJECT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_hit;

  // err_cnt_q counts accepted samples modulo ERR_PERIOD; the one that completes a period is corrupted
  assign err_hit = (state_q == S_PRESENT) && (err_cnt_q == 16'(ERR_PERIOD - 1));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (start_ok) begin
      err_cnt_d = 16'd0;
    end else if (hs) begin
      err_cnt_d = (err_cnt_q == 16'(ERR_PERIOD - 1)) ? 16'd0 : err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_mask = {{(WIDTH-1){1'b0}}, err_hit};
`else
  logic unused_err_period;
  assign unused_err_period = ERR_PERIOD[0];
  assign err_mask          = '0;
`endif

  // state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_WAIT;
      S_WAIT:    if (divcnt_q == 16'd0) state_d = S_PRESENT;
      S_PRESENT: if (hs) state_d = last_hs ? S_DONE : S_WAIT;
      S_DONE:    if (start_ok) state_d = S_WAIT;
      default:   state_d = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    valid      = (state_q == S_PRESENT);
    busy       = (state_q == S_WAIT) || (state_q == S_PRESENT);
    done       = (state_q == S_DONE);
    sample     = valid ? (gen_val ^ err_mask) : '0;
    count      = count_q;
    ref_valid  = ref_vld_q[REF_DELAY-1];
    ref_sample = ref_data_q[REF_DELAY-1];
  end

  always_comb begin
    mode_d   = mode_q;
    div_d    = div_q;
    blen_d   = blen_q;
    divcnt_d = divcnt_q;
    lfsr_d   = lfsr_q;
    ramp_d   = ramp_q;
    count_d  = count_q;
    if (start_ok) begin
      mode_d   = mode;
      div_d    = div;
      blen_d   = burst_len;
      divcnt_d = div;
      lfsr_d   = SeedEff;
      ramp_d   = '0;
      count_d  = 16'd0;
    end else if (hs) begin
      count_d  = count_inc;
      lfsr_d   = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
      ramp_d   = ramp_q + 1'b1;
      divcnt_d = div_q;
    end else if ((state_q == S_WAIT) && (divcnt_q != 16'd0)) begin
      divcnt_d = divcnt_q - 16'd1;
    end
  end

  // reference delay line carries the uncorrupted accepted value
  always_comb begin
    ref_vld_d[0]  = hs;
    ref_data_d[0] = hs ? gen_val : '0;
    for (int i = 1; i < REF_DELAY; i++) begin
      ref_vld_d[i]  = ref_vld_q[i-1];
      ref_data_d[i] = ref_data_q[i-1];
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mode_q    <= 2'b00;
      div_q     <= 16'd0;
      blen_q    <= 16'd0;
      divcnt_q  <= 16'd0;
      lfsr_q    <= SeedEff;
      ramp_q    <= '0;
      count_q   <= 16'd0;
      ref_vld_q <= '0;
      for (int i = 0; i < REF_DELAY; i++) begin
        ref_data_q[i] <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      div_q     <= div_d;
      blen_q    <= blen_d;
      divcnt_q  <= divcnt_d;
      lfsr_q    <= lfsr_d;
      ramp_q    <= ramp_d;
      count_q   <= count_d;
      ref_vld_q <= ref_vld_d;
      for (int i = 0; i < REF_DELAY; i++) begin
        ref_data_q[i] <= ref_data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_audio_prbs_tx.sv
// tb/tb_audio_prbs_tx.sv - table-driven and scoreboard bench for audio_prbs_tx
module tb_audio_prbs_tx;
  localparam int          REF_DELAY  = 4;
  localparam logic [14:0] SEED       = 15'h0001;
  localparam int          ERR_PERIOD = 16;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [15:0] burst_len;
  logic        ready;
  logic [11:0] sample;
  logic        valid;
  logic [11:0] ref_sample;
  logic        ref_valid;
  logic        busy;
  logic        done;
  logic [15:0] count;

  audio_prbs_tx #(
    .WIDTH(12), .SEED(SEED), .REF_DELAY(REF_DELAY), .ERR_PERIOD(ERR_PERIOD)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .mode(mode), .div(div),
    .burst_len(burst_len), .ready(ready), .sample(sample), .valid(valid),
    .ref_sample(ref_sample), .ref_valid(ref_valid), .busy(busy), .done(done),
    .count(count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model of the generators
  logic [14:0] m_lfsr;
  logic [11:0] m_ramp;
  logic [1:0]  m_mode;
  int          m_cnt;
  int          n_diff;

  function automatic logic [11:0] m_value();
    case (m_mode)
      2'b01:   return m_ramp;
      2'b10:   return 12'hA5A;
      default: return m_lfsr[11:0];
    endcase
  endfunction

  typedef struct {
    int          hs_cyc;
    logic [11:0] val;
  } sb_t;
  sb_t sbq[$];

  always @(negedge CLK) begin
    if (!reset) begin
      if (ref_valid) begin
        if (sbq.size() == 0) begin
          chk("ref_unexpected", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("ref_sample", 32'(ref_sample), 32'(e.val));
          chk("ref_latency", 32'(cyc - e.hs_cyc), 32'(REF_DELAY));
        end
      end
      if (valid && ready) begin
        logic [11:0] exp_v;
        logic [11:0] exp_out;
        exp_v   = m_value();
        exp_out = exp_v;
`ifdef AUDIO_PRBS_ERR_INJECT_EN
        if (((m_cnt + 1) % ERR_PERIOD) == 0) exp_out = exp_v ^ 12'h001;
`endif
        if (sample != exp_v) n_diff++;
        chk("hs_sample", 32'(sample), 32'(exp_out));
        sbq.push_back('{hs_cyc: cyc, val: exp_v});
        m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
        m_ramp = m_ramp + 12'd1;
        m_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int start_cyc;

  task automatic do_start(input logic [1:0] md, input logic [15:0] dv, input logic [15:0] bl);
    mode = md; div = dv; burst_len = bl; start = 1'b1;
    m_mode = md; m_lfsr = SEED; m_ramp = 12'd0; m_cnt = 0;
    start_cyc = cyc;
    step();
    start = 1'b0;
    // later input changes must be ignored
    mode = ~md; div = dv + 16'd7; burst_len = bl + 16'd5;
  endtask

  task automatic wait_valid(output bit ok);
    int g = 0;
    while (!valid && g < 200) begin
      step();
      g++;
    end
    ok = valid;
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int g = 0;
    while (!done && g < limit) begin
      step();
      g++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic drain();
    repeat (REF_DELAY + 2) step();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
  endtask

  typedef struct {
    logic [1:0]       md;
    logic [15:0]      dv;
    logic [15:0]      bl;
    logic [3:0][11:0] ex;
  } vec_t;

  task automatic run_burst(input vec_t v);
    bit ok;
    int prev;
    ready = 1'b1;
    do_start(v.md, v.dv, v.bl);
    chk("busy_after_start", 32'(busy), 32'd1);
    prev = start_cyc;
    for (int k = 0; k < int'(v.bl); k++) begin
      wait_valid(ok);
      if (!ok) return;
      chk("valid_cycle", 32'(cyc), (k == 0) ? 32'(start_cyc + 2 + int'(v.dv)) : 32'(prev + int'(v.dv) + 2));
      chk("table_sample", 32'(sample), 32'(v.ex[k]));
      prev = cyc;
      step();
    end
    chk("done_after_last", 32'(done), 32'd1);
    chk("count_after_last", 32'(count), 32'(v.bl));
    chk("busy_after_last", 32'(busy), 32'd0);
    chk("valid_after_last", 32'(valid), 32'd0);
    drain();
  endtask

  vec_t vecs[5];

  initial begin
    bit ok;
    bit saw_done;
    vecs[0] = '{md: 2'b00, dv: 16'd0, bl: 16'd4, ex: {12'h008, 12'h004, 12'h002, 12'h001}};
    vecs[1] = '{md: 2'b01, dv: 16'd2, bl: 16'd3, ex: {12'h000, 12'h002, 12'h001, 12'h000}};
    vecs[2] = '{md: 2'b10, dv: 16'd1, bl: 16'd2, ex: {12'h000, 12'h000, 12'hA5A, 12'hA5A}};
    vecs[3] = '{md: 2'b11, dv: 16'd0, bl: 16'd4, ex: {12'h008, 12'h004, 12'h002, 12'h001}};
    vecs[4] = '{md: 2'b00, dv: 16'd3, bl: 16'd4, ex: {12'h008, 12'h004, 12'h002, 12'h001}};
    n_diff = 0;
    m_lfsr = SEED; m_ramp = 0; m_mode = 0; m_cnt = 0;

    reset = 1'b1; start = 1'b0; mode = 2'b00; div = 16'd0; burst_len = 16'd0; ready = 1'b0;
    step();
    step();
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ref_sample", 32'(ref_sample), 32'd0);
    chk("rst_ref_valid", 32'(ref_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // ready held low in PRESENT
    ready = 1'b0;
    do_start(2'b01, 16'd0, 16'd2);
    wait_valid(ok);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_sample", 32'(sample), 32'h000);
      chk("stall_count", 32'(count), 32'd0);
      chk("stall_ref_valid", 32'(ref_valid), 32'd0);
      step();
    end
    ready = 1'b1;
    wait_done(100);
    chk("stall_count_end", 32'(count), 32'd2);
    drain();

    // start while busy must not restart the burst
    do_start(2'b00, 16'd3, 16'd3);
    wait_valid(ok);
    step();
    start = 1'b1; mode = 2'b10;
    step();
    start = 1'b0;
    wait_done(100);
    chk("busy_start_count", 32'(count), 32'd3);
    drain();

    // continuous ramp across the 12-bit wrap
    saw_done = 1'b0;
    do_start(2'b01, 16'd0, 16'd0);
    for (int k = 0; k < 4097; k++) begin
      wait_valid(ok);
      if (!ok) break;
      if (k == 4095) chk("ramp_fff", 32'(sample), 32'hFFF);
      if (k == 4096) chk("ramp_wrap", 32'(sample), 32'h000);
      saw_done = saw_done | done;
      step();
    end
    chk("cont_no_done", 32'(saw_done | done), 32'd0);
    chk("cont_count", 32'(count), 32'd4097);
    chk("cont_busy", 32'(busy), 32'd1);

    // async reset in WAIT with references still in flight
    reset = 1'b1;
    sbq.delete();
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_sample", 32'(sample), 32'd0);
    chk("arst_ref_valid", 32'(ref_valid), 32'd0);
    chk("arst_ref_sample", 32'(ref_sample), 32'd0);
    step();
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (REF_DELAY + 2) begin
      saw_done = saw_done | ref_valid;
      step();
    end
    chk("arst_no_ref", 32'(saw_done), 32'd0);
    run_burst(vecs[0]);

`ifdef AUDIO_PRBS_ERR_INJECT_EN
    n_diff = 0;
    ready = 1'b1;
    do_start(2'b00, 16'd0, 16'd64);
    wait_done(1000);
    drain();
    chk("inject_diffs", 32'(n_diff), 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
